// File: rtl/parity_stream_acc.sv
// Packet-level streaming parity generator with saturating beat count.
// Optional expected-parity check built when PARITY_CHECK_EN is defined.
module parity_stream_acc #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CNT_W      = 8,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_parity,
`ifdef PARITY_CHECK_EN
    input  logic              exp_parity,
    output logic              out_error,
`endif
    output logic [CNT_W-1:0]  out_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic             acc;
    logic [CNT_W-1:0] cnt;
    logic             par_q;
    logic [CNT_W-1:0] count_q;
    logic             next_acc;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    // acc/cnt are zero in IDLE, so one update formula covers IDLE and ACCUM
    assign next_acc = acc ^ (^in_data);
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    assign accept   = in_valid && (state != DONE);

    // Ready is gated by reset so it reads low while reset_n is held low
    assign in_ready   = reset_n && (state != DONE);
    assign out_valid  = (state == DONE);
    assign out_parity = par_q;
    assign out_count  = count_q;

`ifdef PARITY_CHECK_EN
    logic err_q;
    assign out_error = err_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            acc     <= 1'b0;
            cnt     <= '0;
            par_q   <= 1'b0;
            count_q <= '0;
`ifdef PARITY_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (in_last) begin
                            state   <= DONE;
                            par_q   <= next_acc ^ ODD_PARITY;
                            count_q <= cnt_inc;
`ifdef PARITY_CHECK_EN
                            err_q   <= (next_acc ^ ODD_PARITY) != exp_parity;
`endif
                        end else begin
                            state <= ACCUM;
                            acc   <= next_acc;
                            cnt   <= cnt_inc;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                        acc   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_stream_acc.sv
// Self-checking bench: default, odd-parity and CNT_W=2 instances share one stimulus.
module tb_parity_stream_acc;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;
    logic       exp_parity;

    logic       rdy0, rdy1, rdy2;
    logic       val0, val1, val2;
    logic       par0, par1, par2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic       err0, err1, err2;

    int checks = 0;
    int errors = 0;

    parity_stream_acc #(.DATA_W(8), .CNT_W(8), .ODD_PARITY(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_last(in_last), .out_valid(val0), .out_ready(out_ready),
        .out_parity(par0),
`ifdef PARITY_CHECK_EN
        .exp_parity(exp_parity), .out_error(err0),
`endif
        .out_count(cnt0));

    parity_stream_acc #(.DATA_W(8), .CNT_W(8), .ODD_PARITY(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_last(in_last), .out_valid(val1), .out_ready(out_ready),
        .out_parity(par1),
`ifdef PARITY_CHECK_EN
        .exp_parity(exp_parity), .out_error(err1),
`endif
        .out_count(cnt1));

    parity_stream_acc #(.DATA_W(8), .CNT_W(2), .ODD_PARITY(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy2),
        .in_data(in_data), .in_last(in_last), .out_valid(val2), .out_ready(out_ready),
        .out_parity(par2),
`ifdef PARITY_CHECK_EN
        .exp_parity(exp_parity), .out_error(err2),
`endif
        .out_count(cnt2));

`ifndef PARITY_CHECK_EN
    assign err0 = 1'b0;
    assign err1 = 1'b0;
    assign err2 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       ordy;
        logic       e_valid;
        logic       e_ready;
        logic       e_par0;
        logic       e_par1;
        logic [7:0] e_cnt0;
        logic [1:0] e_cnt2;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                                input logic o, input logic ev, input logic er,
                                input logic p0, input logic p1,
                                input logic [7:0] c0, input logic [1:0] c2);
        vec_t r;
        r.valid = v; r.data = d; r.last = l; r.ordy = o;
        r.e_valid = ev; r.e_ready = er; r.e_par0 = p0; r.e_par1 = p1;
        r.e_cnt0 = c0; r.e_cnt2 = c2;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic o);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = o;
    endtask

    initial begin
        // valid data last ordy | e_valid e_ready par0 par1 cnt0 cnt2
        vecs[0]  = mk(1, 8'hA5, 1, 0,  1, 0, 0, 1, 8'd1, 2'd1);
        vecs[1]  = mk(0, 8'h00, 0, 1,  0, 1, 0, 0, 8'd0, 2'd0);
        vecs[2]  = mk(1, 8'h01, 0, 0,  0, 1, 0, 0, 8'd0, 2'd0);
        vecs[3]  = mk(0, 8'hFF, 0, 0,  0, 1, 0, 0, 8'd0, 2'd0);
        vecs[4]  = mk(0, 8'hFF, 1, 0,  0, 1, 0, 0, 8'd0, 2'd0);
        vecs[5]  = mk(1, 8'h03, 0, 0,  0, 1, 0, 0, 8'd0, 2'd0);
        vecs[6]  = mk(1, 8'h80, 1, 0,  1, 0, 0, 1, 8'd3, 2'd3);
        vecs[7]  = mk(0, 8'h00, 0, 1,  0, 1, 0, 0, 8'd0, 2'd0);
        vecs[8]  = mk(1, 8'h01, 0, 0,  0, 1, 0, 0, 8'd0, 2'd0);
        vecs[9]  = mk(1, 8'h01, 0, 0,  0, 1, 0, 0, 8'd0, 2'd0);
        vecs[10] = mk(1, 8'h01, 0, 0,  0, 1, 0, 0, 8'd0, 2'd0);
        vecs[11] = mk(1, 8'h01, 0, 0,  0, 1, 0, 0, 8'd0, 2'd0);
        vecs[12] = mk(1, 8'h01, 0, 0,  0, 1, 0, 0, 8'd0, 2'd0);
        vecs[13] = mk(1, 8'h01, 1, 0,  1, 0, 0, 1, 8'd6, 2'd3);
        vecs[14] = mk(0, 8'h00, 0, 1,  0, 1, 0, 0, 8'd0, 2'd0);
        vecs[15] = mk(1, 8'h07, 1, 0,  1, 0, 1, 0, 8'd1, 2'd1);
        vecs[16] = mk(0, 8'h00, 0, 1,  0, 1, 0, 0, 8'd0, 2'd0);

        reset_n    = 1'b0;
        exp_parity = 1'b0;
        drive(0, 8'h00, 0, 0);
        #2;
        chk("reset in_ready", rdy0, 0);
        chk("reset out_valid", val0, 0);
        chk("reset out_parity", par0, 0);
        chk("reset out_count", cnt0, 0);
        chk("reset out_error", err0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post-reset in_ready", rdy0, 1);
        chk("post-reset out_valid", val0, 0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].ordy);
            tick();
            chk($sformatf("vec%0d out_valid", i), val0, vecs[i].e_valid);
            chk($sformatf("vec%0d in_ready", i), rdy0, vecs[i].e_ready);
            chk($sformatf("vec%0d w2 out_valid", i), val2, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d even parity", i), par0, vecs[i].e_par0);
                chk($sformatf("vec%0d odd parity", i), par1, vecs[i].e_par1);
                chk($sformatf("vec%0d count", i), cnt0, vecs[i].e_cnt0);
                chk($sformatf("vec%0d sat count", i), cnt2, vecs[i].e_cnt2);
                chk($sformatf("vec%0d w2 parity", i), par2, vecs[i].e_par0);
            end
        end

        // Backpressure: result 0x0F then a new beat held off for 5 cycles
        @(negedge clk);
        drive(1, 8'h0F, 1, 0);
        tick();
        chk("bp first valid", val0, 1);
        chk("bp first parity", par0, 0);
        drive(1, 8'h01, 1, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp%0d in_ready", c), rdy0, 0);
            chk($sformatf("bp%0d out_valid", c), val0, 1);
            chk($sformatf("bp%0d parity", c), par0, 0);
            chk($sformatf("bp%0d odd parity", c), par1, 1);
            chk($sformatf("bp%0d count", c), cnt0, 1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp release out_valid", val0, 0);
        chk("bp release in_ready", rdy0, 1);
        out_ready = 1'b0;
        tick();
        chk("bp new beat valid", val0, 1);
        chk("bp new beat parity", par0, 1);
        chk("bp new beat count", cnt0, 1);
        drive(0, 8'h00, 0, 1);
        tick();
        chk("bp drain", val0, 0);

        // Reset mid-packet with a held result register and acc=1, cnt=2
        drive(1, 8'h01, 0, 0);
        tick();
        drive(1, 8'h03, 0, 0);
        tick();
        drive(0, 8'h00, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid-reset in_ready", rdy0, 0);
        chk("mid-reset out_valid", val0, 0);
        chk("mid-reset out_parity", par0, 0);
        chk("mid-reset out_count", cnt0, 0);
        chk("mid-reset odd parity", par1, 0);
        #1;
        reset_n = 1'b1;
        #1;
        chk("after reset in_ready", rdy0, 1);
        @(negedge clk);
        drive(1, 8'h01, 1, 0);
        tick();
        chk("after reset valid", val0, 1);
        chk("after reset parity", par0, 1);
        chk("after reset count", cnt0, 1);
        chk("after reset sat count", cnt2, 1);
        drive(0, 8'h00, 0, 1);
        tick();

`ifdef PARITY_CHECK_EN
        @(negedge clk);
        drive(1, 8'h07, 1, 0);
        exp_parity = 1'b0;
        tick();
        chk("chk0 parity", par0, 1);
        chk("chk0 error", err0, 1);
        chk("chk0 odd error", err1, 0);
        drive(0, 8'h00, 0, 1);
        exp_parity = 1'b1;
        tick();
        drive(1, 8'h07, 1, 0);
        tick();
        exp_parity = 1'b0;
        chk("chk1 parity", par0, 1);
        chk("chk1 error", err0, 0);
        chk("chk1 odd error", err1, 1);
        drive(0, 8'h00, 0, 0);
        tick();
        chk("chk1 error held", err0, 0);
        drive(0, 8'h00, 0, 1);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
